// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that steps the shared-memory datapath
// through fetch, decode, execute, memory and writeback for each instruction.
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT        = 1,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int ALUOP_W         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               zeroext,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic               instr_done,
    output logic               illegal,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_ORIEX  = 4'd12,
        S_BNE    = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       rdy;
    logic [1:0] aluop_base;

    assign rdy   = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign state = state_q;

    // reset is active-low despite its name
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_BNE:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_IMMWB;
            S_ORIEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is asserted so no strobe leaks out
    always_comb begin
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        aluop_base = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = rdy;
                    pcen    = rdy;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    if (TRAP_ON_ILLEGAL == 0) begin
                        case (op)
                            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                            OP_ADDI, OP_ORI, OP_J: illegal = 1'b0;
                            default:               illegal = 1'b1;
                        endcase
                    end
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = rdy;
                end
                S_RTEX: begin
                    alusrca    = 1'b1;
                    aluop_base = 2'b10;
                end
                S_ALUWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ, S_BNE: begin
                    alusrca    = 1'b1;
                    aluop_base = 2'b01;
                    pcsrc      = 2'b01;
                    pcen       = (state_q == S_BEQ) ? zero : ~zero;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ORIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    zeroext    = 1'b1;
                    aluop_base = 2'b11;
                end
                S_IMMWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pcsrc      = 2'b10;
                    pcen       = 1'b1;
                    instr_done = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

    always_comb begin
        aluop      = '0;
        aluop[1:0] = aluop_base;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one trapping/waiting instance and one
// non-trapping, wait-ignoring instance, each checked against hand-computed controls.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       instr_done;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [5:0] op_a, op_b;
    logic       zero;
    logic       rdy_a, rdy_b;
    ctl_t       ca, cb;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT(1), .TRAP_ON_ILLEGAL(1), .ALUOP_W(2)) dut_a (
        .clk(clk), .reset(reset_a), .op(op_a), .zero(zero), .mem_ready(rdy_a),
        .iord(ca.iord), .memread(ca.memread), .memwrite(ca.memwrite),
        .irwrite(ca.irwrite), .regwrite(ca.regwrite), .regdst(ca.regdst),
        .memtoreg(ca.memtoreg), .alusrca(ca.alusrca), .alusrcb(ca.alusrcb),
        .zeroext(ca.zeroext), .aluop(ca.aluop), .pcsrc(ca.pcsrc), .pcen(ca.pcen),
        .instr_done(ca.instr_done), .illegal(ca.illegal), .state(ca.state)
    );

    mips_multicycle_ctrl #(.MEM_WAIT(0), .TRAP_ON_ILLEGAL(0), .ALUOP_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .op(op_b), .zero(zero), .mem_ready(rdy_b),
        .iord(cb.iord), .memread(cb.memread), .memwrite(cb.memwrite),
        .irwrite(cb.irwrite), .regwrite(cb.regwrite), .regdst(cb.regdst),
        .memtoreg(cb.memtoreg), .alusrca(cb.alusrca), .alusrcb(cb.alusrcb),
        .zeroext(cb.zeroext), .aluop(cb.aluop), .pcsrc(cb.pcsrc), .pcen(cb.pcen),
        .instr_done(cb.instr_done), .illegal(cb.illegal), .state(cb.state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        op_a = 6'b000000; op_b = 6'b000000;
        zero = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        #2;
        chk("rst_a_all", 32'(ca), 0);
        chk("rst_b_all", 32'(cb), 0);

        reset_a = 1'b1;
        #1;
        chk("fetch_state", 32'(ca.state), 0);
        chk("fetch_memread", 32'(ca.memread), 1);
        chk("fetch_irwrite", 32'(ca.irwrite), 1);
        chk("fetch_pcen", 32'(ca.pcen), 1);
        chk("fetch_alusrcb", 32'(ca.alusrcb), 1);

        // LW, memory always ready
        op_a = 6'b100011;
        tick();
        chk("lw_s1", 32'(ca.state), 1);
        chk("lw_dec_alusrcb", 32'(ca.alusrcb), 3);
        chk("lw_dec_memread", 32'(ca.memread), 0);
        tick();
        chk("lw_s2", 32'(ca.state), 2);
        chk("lw_adr_srca", 32'(ca.alusrca), 1);
        chk("lw_adr_srcb", 32'(ca.alusrcb), 2);
        tick();
        chk("lw_s3", 32'(ca.state), 3);
        chk("lw_rd_iord", 32'(ca.iord), 1);
        chk("lw_rd_memread", 32'(ca.memread), 1);
        chk("lw_rd_regwrite", 32'(ca.regwrite), 0);
        chk("lw_rd_done", 32'(ca.instr_done), 0);
        tick();
        chk("lw_s4", 32'(ca.state), 4);
        chk("lw_wb_regwrite", 32'(ca.regwrite), 1);
        chk("lw_wb_memtoreg", 32'(ca.memtoreg), 1);
        chk("lw_wb_done", 32'(ca.instr_done), 1);
        tick();
        chk("lw_back_s0", 32'(ca.state), 0);
        chk("lw_back_done", 32'(ca.instr_done), 0);
        chk("lw_back_regwrite", 32'(ca.regwrite), 0);

        // SW with three wait cycles in MEMWR
        op_a = 6'b101011;
        tick();
        tick();
        chk("sw_s2", 32'(ca.state), 2);
        rdy_a = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sw_wait_state", 32'(ca.state), 5);
            chk("sw_wait_memwrite", 32'(ca.memwrite), 1);
            chk("sw_wait_iord", 32'(ca.iord), 1);
            chk("sw_wait_done", 32'(ca.instr_done), 0);
            chk("sw_wait_regwrite", 32'(ca.regwrite), 0);
            tick();
        end
        rdy_a = 1'b1;
        #1;
        chk("sw_rdy_state", 32'(ca.state), 5);
        chk("sw_rdy_memwrite", 32'(ca.memwrite), 1);
        chk("sw_rdy_done", 32'(ca.instr_done), 1);
        chk("sw_rdy_regwrite", 32'(ca.regwrite), 0);
        tick();
        chk("sw_back_s0", 32'(ca.state), 0);

        // Reset asserted in the middle of a stalled store
        tick();
        tick();
        rdy_a = 1'b0;
        tick();
        chk("abort_pre_state", 32'(ca.state), 5);
        chk("abort_pre_memwrite", 32'(ca.memwrite), 1);
        reset_a = 1'b0;
        #1;
        chk("abort_all", 32'(ca), 0);
        reset_a = 1'b1;
        #1;
        chk("abort_rel_state", 32'(ca.state), 0);
        chk("abort_rel_memread", 32'(ca.memread), 1);
        chk("abort_rel_memwrite", 32'(ca.memwrite), 0);
        rdy_a = 1'b1;

        // BEQ taken
        op_a = 6'b000100;
        zero = 1'b1;
        tick();
        tick();
        chk("beq_state", 32'(ca.state), 8);
        chk("beq_pcen", 32'(ca.pcen), 1);
        chk("beq_pcsrc", 32'(ca.pcsrc), 1);
        chk("beq_aluop", 32'(ca.aluop), 1);
        chk("beq_done", 32'(ca.instr_done), 1);
        tick();

        // BNE with zero=1 then zero=0 in the same state
        op_a = 6'b000101;
        tick();
        tick();
        chk("bne_state", 32'(ca.state), 13);
        chk("bne_z1_pcen", 32'(ca.pcen), 0);
        zero = 1'b0;
        #1;
        chk("bne_z0_pcen", 32'(ca.pcen), 1);
        chk("bne_pcsrc", 32'(ca.pcsrc), 1);
        tick();

        // ORI
        op_a = 6'b001101;
        tick();
        tick();
        chk("ori_state", 32'(ca.state), 12);
        chk("ori_aluop", 32'(ca.aluop), 3);
        chk("ori_zeroext", 32'(ca.zeroext), 1);
        chk("ori_alusrcb", 32'(ca.alusrcb), 2);
        tick();
        chk("immwb_state", 32'(ca.state), 10);
        chk("immwb_regwrite", 32'(ca.regwrite), 1);
        chk("immwb_regdst", 32'(ca.regdst), 0);
        chk("immwb_zeroext", 32'(ca.zeroext), 0);
        tick();

        // R-type
        op_a = 6'b000000;
        tick();
        tick();
        chk("rtex_state", 32'(ca.state), 6);
        chk("rtex_aluop", 32'(ca.aluop), 2);
        chk("rtex_alusrcb", 32'(ca.alusrcb), 0);
        tick();
        chk("aluwb_state", 32'(ca.state), 7);
        chk("aluwb_regdst", 32'(ca.regdst), 1);
        chk("aluwb_regwrite", 32'(ca.regwrite), 1);
        tick();

        // ADDI
        op_a = 6'b001000;
        tick();
        tick();
        chk("addi_state", 32'(ca.state), 9);
        chk("addi_aluop", 32'(ca.aluop), 0);
        chk("addi_zeroext", 32'(ca.zeroext), 0);
        tick();
        chk("addi_wb_state", 32'(ca.state), 10);
        tick();

        // J
        op_a = 6'b000010;
        tick();
        tick();
        chk("j_state", 32'(ca.state), 11);
        chk("j_pcsrc", 32'(ca.pcsrc), 2);
        chk("j_pcen", 32'(ca.pcen), 1);
        chk("j_done", 32'(ca.instr_done), 1);
        tick();
        chk("j_back_s0", 32'(ca.state), 0);

        // Illegal opcode traps until reset
        op_a = 6'b111111;
        tick();
        chk("trap_dec_illegal", 32'(ca.illegal), 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("trap_state", 32'(ca.state), 14);
            chk("trap_illegal", 32'(ca.illegal), 1);
            chk("trap_strobes", 32'({ca.memread, ca.memwrite, ca.irwrite, ca.regwrite, ca.pcen, ca.instr_done}), 0);
            tick();
        end

        // Instance B: mem_ready ignored, LW still 5 cycles
        rdy_b = 1'b0;
        op_b = 6'b100011;
        reset_b = 1'b1;
        #1;
        chk("b_fetch_state", 32'(cb.state), 0);
        chk("b_fetch_pcen", 32'(cb.pcen), 1);
        tick();
        chk("b_lw_s1", 32'(cb.state), 1);
        tick();
        chk("b_lw_s2", 32'(cb.state), 2);
        tick();
        chk("b_lw_s3", 32'(cb.state), 3);
        chk("b_lw_memread", 32'(cb.memread), 1);
        tick();
        chk("b_lw_s4", 32'(cb.state), 4);
        chk("b_lw_done", 32'(cb.instr_done), 1);
        tick();
        chk("b_lw_back_s0", 32'(cb.state), 0);

        // Instance B: illegal pulses for one cycle in DECODE, then FETCH
        op_b = 6'b111111;
        tick();
        chk("b_ill_state", 32'(cb.state), 1);
        chk("b_ill_flag", 32'(cb.illegal), 1);
        chk("b_ill_done", 32'(cb.instr_done), 0);
        tick();
        chk("b_ill_back_state", 32'(cb.state), 0);
        chk("b_ill_back_flag", 32'(cb.illegal), 0);
        chk("b_ill_back_memread", 32'(cb.memread), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control unit for the MIPS datapath; replaces the single-cycle opcode decoder with a Moore FSM that issues per-step datapath controls.
- Supports R-type, LW, SW, BEQ, BNE, ADDI, ORI and J.
- Adds a memory ready handshake, illegal-opcode trapping and an instruction-retire pulse.
- Sits between the instruction register opcode field and the shared-memory multicycle datapath.

Parameters:
- MEM_WAIT, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters TRAP until reset; 0 = illegal opcode pulses illegal and returns to FETCH.
- ALUOP_W, 2: aluop width; bits above [1:0] driven 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- regdst  out  1  destination: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback: 0 = ALUOut, 1 = data register.
- alusrca  out  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate shifted left 2.
- zeroext  out  1  immediate zero-extend (ORI) instead of sign-extend.
- aluop  out  ALUOP_W  00 = add, 01 = sub, 10 = funct, 11 = or.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC write enable.
- instr_done  out  1  one-cycle retire pulse.
- illegal  out  1  illegal opcode flag.
- state  out  4  current state, for debug.

Behaviour:
- Moore FSM, 4-bit state register.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7, BEQ=8, ADDIEX=9, IMMWB=10, JUMP=11, ORIEX=12, BNE=13, TRAP=14. Code 15 unreachable; it is treated as FETCH next cycle.
- reset low, asynchronous: state=FETCH. While reset is low, all outputs are 0. Reset mid-instruction aborts it with no write; restart at FETCH after release.
- Outputs are combinational from state (plus zero/mem_ready where noted). Any control not listed for a state is 0.
- "rdy" below means mem_ready when MEM_WAIT=1, else constant 1.
- FETCH: memread=1, alusrcb=01, irwrite=rdy, pcen=rdy. Go to DECODE when rdy, else stay.
- DECODE: alusrcb=11. Next state by op:
  - 000000 -> RTEX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 000101 -> BNE
  - 001000 -> ADDIEX
  - 001101 -> ORIEX
  - 000010 -> JUMP
  - other -> TRAP if TRAP_ON_ILLEGAL, else FETCH with illegal=1 and instr_done=0 for that cycle.
- MEMADR: alusrca=1, alusrcb=10. Go to MEMRD if op=100011, else MEMWR.
- MEMRD: iord=1, memread=1. Go to MEMWB when rdy, else stay.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1. Go to FETCH.
- MEMWR: iord=1, memwrite=1, held every cycle while waiting; the store commits on the rdy cycle. instr_done=rdy. Go to FETCH when rdy.
- RTEX: alusrca=1, aluop=10. Go to ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Go to FETCH.
- BEQ: alusrca=1, aluop=01, pcsrc=01, pcen=zero, instr_done=1. Go to FETCH.
- BNE: same as BEQ except pcen=~zero.
- ADDIEX: alusrca=1, alusrcb=10. Go to IMMWB.
- ORIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=11. Go to IMMWB.
- IMMWB: regwrite=1, instr_done=1. Go to FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Go to FETCH.
- TRAP: illegal=1 constant, all other controls 0. Stays until reset.
- The opcode is sampled only in DECODE and MEMADR; it must be stable from the FETCH rdy edge onward.
- Cycle counts with mem_ready always 1:
  - LW 5
  - SW 4
  - R-type, ADDI, ORI 4
  - BEQ, BNE, J 3
- Each wait cycle adds exactly 1 cycle.

Test Plan:
- Reset low mid-MEMWR with memwrite=1 -> same-cycle state=0 and all outputs 0; after release, FETCH issues memread=1.
- LW (op=100011), mem_ready=1 throughout -> state sequence 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; instr_done one pulse at cycle 5.
- SW (op=101011), mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles; instr_done only on the mem_ready cycle; regwrite never asserted.
- BEQ with zero=1 -> pcen=1 and pcsrc=01 in state 8. BNE with zero=1 -> pcen=0 in state 13. BNE with zero=0 -> pcen=1.
- ORI (op=001101) -> state 12 drives aluop=11, zeroext=1, alusrcb=10; state 10 drives regwrite=1 and regdst=0. J (op=000010) -> pcsrc=10 and pcen=1 in state 11.
- op=111111 with TRAP_ON_ILLEGAL=1 -> state 14, illegal stuck at 1 for 20 cycles, no write strobes. With TRAP_ON_ILLEGAL=0 -> illegal pulses 1 cycle, then back to FETCH. With MEM_WAIT=0 and mem_ready=0 -> LW still completes in 5 cycles.
